alm_product_accumulator: RTL and testbench

// - Downstream stage of the ALM_SOA approximate log multiplier. It takes the 17-bit
//   two's-complement product stream (p) and sums the products of one frame into a

---
 rtl/alm_product_accumulator_pkg.sv | 15 +
 rtl/alm_product_accumulator_if.sv | 27 ++
 rtl/alm_sat_add.sv | 25 ++
 rtl/alm_product_accumulator.sv | 100 ++++++++++
 tb/tb_alm_product_accumulator.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alm_product_accumulator_pkg.sv
// Shared types and default widths for the ALM_SOA product accumulator.
package alm_product_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int P_W_DEF     = 17;
    localparam int ACC_W_DEF   = 24;
    localparam int MAX_LEN_DEF = 256;
    localparam int CNT_W_DEF   = 9;

endpackage

// File: rtl/alm_product_accumulator_if.sv
// Product stream in, frame result out: both valid/ready handshakes plus flush.
interface alm_product_accumulator_if #(
    parameter int P_W   = 17,
    parameter int ACC_W = 24,
    parameter int CNT_W = 9
);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [P_W-1:0]   in_p;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0]        out_count;
    logic                    out_sat;

    modport master (
        output flush, in_valid, in_p, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_sat
    );

    modport slave (
        input  flush, in_valid, in_p, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_sat
    );
endinterface

// File: rtl/alm_sat_add.sv
// Combinational signed adder that clamps to the ACC_W range instead of wrapping.
module alm_sat_add #(
    parameter int ACC_W = 24
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum_sat,
    output logic                    ovf
);

    logic signed [ACC_W:0] wide;

    // The two top bits of the one-bit-wider sum disagree exactly when ACC_W overflowed.
    function automatic logic [ACC_W:0] sat_clip(input logic signed [ACC_W:0] s);
        case ({s[ACC_W], s[ACC_W-1]})
            2'b01:   return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            2'b10:   return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            default: return {1'b0, s[ACC_W-1:0]};
        endcase
    endfunction

    assign wide           = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    assign {ovf, sum_sat} = sat_clip(wide);

endmodule

// File: rtl/alm_product_accumulator.sv
// Sums one frame of signed ALM_SOA products into a saturating accumulator and hands out one result per frame.
module alm_product_accumulator
    import alm_product_accumulator_pkg::*;
#(
    parameter int P_W     = P_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    alm_product_accumulator_if.slave bus
);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_nxt;
    logic                    sat;
    logic                    ovf;
    logic                    accept;
    logic                    rel;
    logic                    first_close;
    logic                    next_close;

    assign p_ext       = {{(ACC_W-P_W){bus.in_p[P_W-1]}}, bus.in_p};
    assign count_nxt   = count + CNT_W'(1);
    assign first_close = bus.in_last || (MAX_LEN == 1);
    assign next_close  = bus.in_last || (count_nxt == CNT_W'(MAX_LEN));

    // In HOLD the input is only open when the result leaves in the same cycle.
    assign bus.in_ready  = !bus.flush && ((state != HOLD) || bus.out_ready);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_acc   = acc;
    assign bus.out_count = count;
    assign bus.out_sat   = sat;

    assign accept = bus.in_valid && bus.in_ready;
    assign rel    = bus.out_valid && bus.out_ready && !bus.flush;

    alm_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a       (acc),
        .b       (p_ext),
        .sum_sat (sum),
        .ovf     (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= p_ext;
                        count <= CNT_W'(1);
                        sat   <= 1'b0;
                        state <= first_close ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc   <= sum;
                        count <= count_nxt;
                        sat   <= sat | ovf;
                        state <= next_close ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    // A beat accepted here opens the next frame with no idle cycle.
                    if (rel && accept) begin
                        acc   <= p_ext;
                        count <= CNT_W'(1);
                        sat   <= 1'b0;
                        state <= first_close ? HOLD : ACCUM;
                    end else if (rel) begin
                        acc   <= '0;
                        count <= '0;
                        sat   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alm_product_accumulator.sv
// Scoreboard bench: a reference model queues frame results as beats are accepted; a monitor checks releases.
module tb_alm_product_accumulator;

    localparam int P_W     = 17;
    localparam int ACC_W   = 18;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 9;
    localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

    typedef struct {
        longint acc;
        longint cnt;
        longint sat;
    } exp_t;

    logic   clk;
    logic   rst_n;
    int     checks;
    int     errors;
    exp_t   q[$];
    longint m_acc;
    int     m_cnt;
    bit     m_sat;
    bit     m_open;

    alm_product_accumulator_if #(.P_W(P_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    alm_product_accumulator #(
        .P_W(P_W), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_beat(input longint p, input bit last);
        longint s;
        if (!m_open) begin
            m_acc  = p;
            m_cnt  = 1;
            m_sat  = 1'b0;
            m_open = 1'b1;
        end else begin
            s = m_acc + p;
            if (s > MAXV) begin
                s     = MAXV;
                m_sat = 1'b1;
            end else if (s < MINV) begin
                s     = MINV;
                m_sat = 1'b1;
            end
            m_acc = s;
            m_cnt++;
        end
        if (last || m_cnt == MAX_LEN) begin
            q.push_back('{acc: m_acc, cnt: longint'(m_cnt), sat: longint'(m_sat)});
            m_open = 1'b0;
        end
    endtask

    task automatic send_beat(input int p, input bit last);
        bit ok;
        bit closes;
        bus.in_valid = 1'b1;
        bus.in_p     = P_W'(p);
        bus.in_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_wait", longint'(ok), 1);
        closes = last || (m_open && m_cnt + 1 == MAX_LEN) || (!m_open && MAX_LEN == 1);
        if (ok) model_beat(longint'(p), last);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (ok && closes) chk("latency_valid", longint'(bus.out_valid), 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_acc", longint'(bus.out_acc), e.acc);
                chk("out_count", longint'(bus.out_count), e.cnt);
                chk("out_sat", longint'(bus.out_sat), e.sat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        m_open = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        m_sat = 1'b0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_p = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_out_acc", longint'(bus.out_acc), 0);
        chk("rst_out_count", longint'(bus.out_count), 0);
        chk("rst_out_sat", longint'(bus.out_sat), 0);

        // basic and signed frames
        send_beat(15, 0); send_beat(75, 0); send_beat(80, 1);
        idle(2);
        send_beat(-16, 0); send_beat(16, 0); send_beat(-1, 1);
        idle(2);

        // saturation then continue from the clamp
        send_beat(65535, 0); send_beat(65535, 0); send_beat(65535, 0); send_beat(-1, 1);
        idle(2);

        // back-pressure in HOLD, then release with a same-cycle first beat
        bus.out_ready = 1'b0;
        send_beat(1, 0); send_beat(2, 1);
        bus.in_valid = 1'b1;
        bus.in_p     = P_W'(7);
        bus.in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", longint'(bus.in_ready), 0);
            chk("stall_out_valid", longint'(bus.out_valid), 1);
            chk("stall_out_acc", longint'(bus.out_acc), 3);
            chk("stall_out_count", longint'(bus.out_count), 2);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_beat(7, 0);
        chk("nobubble_valid", longint'(bus.out_valid), 0);
        chk("nobubble_acc", longint'(bus.out_acc), 7);
        chk("nobubble_count", longint'(bus.out_count), 1);
        send_beat(8, 1);
        send_beat(1, 1);
        send_beat(2, 1);
        idle(2);

        // forced close at MAX_LEN, then the tail frame
        for (int i = 0; i < 6; i++) send_beat(1, i == 5);
        idle(2);

        // flush in ACCUM
        send_beat(3, 0); send_beat(4, 0);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", longint'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        m_open = 1'b0;
        chk("flush_count", longint'(bus.out_count), 0);
        send_beat(5, 1);
        idle(2);

        // flush drops a pending result
        bus.out_ready = 1'b0;
        send_beat(9, 1);
        void'(q.pop_back());
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_hold_valid", longint'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        idle(2);

        // async reset while holding a result
        bus.out_ready = 1'b0;
        send_beat(6, 1);
        void'(q.pop_back());
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", longint'(bus.out_valid), 0);
        chk("async_rst_acc", longint'(bus.out_acc), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        chk("post_rst_in_ready", longint'(bus.in_ready), 1);
        chk("post_rst_count", longint'(bus.out_count), 0);
        send_beat(10, 1);
        idle(5);

        chk("queue_empty", longint'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
